// File: rtl/ospi_flash_arbiter.sv
// ospi_flash_arbiter: two-requester round-robin arbiter driving a read/write/erase flash strobe interface
module ospi_flash_arbiter #(
    parameter int WIDTH     = 8,
    parameter int RD_LAT    = 2,
    parameter int ERASE_CYC = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         req,
    input  logic [3:0]         op,
    input  logic [2*WIDTH-1:0] addr,
    input  logic [2*WIDTH-1:0] wdata,
    output logic [1:0]         ack,
    output logic               err,
    output logic [WIDTH-1:0]   rdata,
    output logic               busy,
    output logic               read_enable,
    output logic               write_enable,
    output logic               erase_enable,
    output logic [WIDTH-1:0]   address,
    output logic [WIDTH-1:0]   data_in,
    input  logic [WIDTH-1:0]   data_out
);
    localparam int MAXC = (RD_LAT > ERASE_CYC) ? RD_LAT : ERASE_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_op;
    logic            r_win;
    logic            r_last;
    logic            w_win;
    logic [1:0]      w_op;
    logic [WIDTH-1:0] w_addr;
    logic [WIDTH-1:0] w_wdata;

    // Winner selection: on a tie the requester not granted last time wins
    always_comb begin
        w_win   = (req == 2'b11) ? ~r_last : req[1];
        w_op    = w_win ? op[3:2] : op[1:0];
        w_addr  = w_win ? addr[WIDTH +: WIDTH] : addr[0 +: WIDTH];
        w_wdata = w_win ? wdata[WIDTH +: WIDTH] : wdata[0 +: WIDTH];
    end

    // Transaction FSM with registered strobes, ack and flash bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_op         <= 2'b00;
            r_win        <= 1'b0;
            r_last       <= 1'b1;
            ack          <= 2'b00;
            err          <= 1'b0;
            rdata        <= '0;
            busy         <= 1'b0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            erase_enable <= 1'b0;
            address      <= '0;
            data_in      <= '0;
        end else begin
            ack          <= 2'b00;
            err          <= 1'b0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            erase_enable <= 1'b0;
            case (r_state)
                S_IDLE: if (|req) begin
                    r_win   <= w_win;
                    r_op    <= w_op;
                    address <= w_addr;
                    data_in <= w_wdata;
                    busy    <= 1'b1;
                    if (w_op == 2'b11) begin
                        r_state <= S_DONE;
                        ack     <= w_win ? 2'b10 : 2'b01;
                        err     <= 1'b1;
                    end else begin
                        r_state      <= S_ISSUE;
                        read_enable  <= (w_op == 2'b00);
                        write_enable <= (w_op == 2'b01);
                        erase_enable <= (w_op == 2'b10);
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= (r_op == 2'b00) ? CW'(RD_LAT) : (r_op == 2'b01) ? CW'(1) : CW'(ERASE_CYC);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                        ack     <= r_win ? 2'b10 : 2'b01;
                        if (r_op == 2'b00) rdata <= data_out;
                    end
                end
                S_DONE: begin
                    r_last  <= r_win;
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ospi_flash_arbiter.sv
// tb_ospi_flash_arbiter: directed scenario bench for ospi_flash_arbiter
module tb_ospi_flash_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [3:0]  op = 4'b0000;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [7:0]  data_out = 8'h00;
    logic [1:0]  ack;
    logic        err;
    logic [7:0]  rdata;
    logic        busy;
    logic        read_enable;
    logic        write_enable;
    logic        erase_enable;
    logic [7:0]  address;
    logic [7:0]  data_in;
    int          errors = 0;
    int          checks = 0;

    ospi_flash_arbiter #(.WIDTH(8), .RD_LAT(2), .ERASE_CYC(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .read_enable(read_enable), .write_enable(write_enable), .erase_enable(erase_enable),
        .address(address), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    wire [2:0]  strobes = {read_enable, write_enable, erase_enable};
    wire [29:0] all_out = {ack, err, rdata, busy, read_enable, write_enable, erase_enable, address, data_in};

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        checks++; if (all_out !== 30'd0) begin errors++; $display("FAIL reset_async got %h exp 0", all_out); end
        repeat (2) @(negedge clk);
        checks++; if (all_out !== 30'd0) begin errors++; $display("FAIL reset_held got %h exp 0", all_out); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (all_out !== 30'd0) begin errors++; $display("FAIL reset_release got %h exp 0", all_out); end
    endtask

    task automatic test_contention();
        req = 2'b11; op = 4'b1001; addr = 16'h7755; wdata = 16'h003C;
        @(negedge clk);
        checks++; if (strobes !== 3'b010) begin errors++; $display("FAIL cont_wr_strobe got %b exp 010", strobes); end
        checks++; if ({address, data_in} !== 16'h553C) begin errors++; $display("FAIL cont_wr_bus got %h exp 553c", {address, data_in}); end
        @(negedge clk);
        checks++; if ({ack, strobes} !== 5'd0) begin errors++; $display("FAIL cont_wr_wait got %b exp 0", {ack, strobes}); end
        @(negedge clk);
        checks++; if ({ack, err} !== 3'b010) begin errors++; $display("FAIL cont_ack0 got %b exp 010", {ack, err}); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle got %b exp 0", busy); end
        @(negedge clk);
        checks++; if ({strobes, address} !== {3'b001, 8'h77}) begin errors++; $display("FAIL cont_erase_strobe got %h exp 177", {strobes, address}); end
        req = 2'b00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++; if ({ack, strobes} !== 5'd0) begin errors++; $display("FAIL cont_erase_wait%0d got %b exp 0", i, {ack, strobes}); end
        end
        @(negedge clk);
        checks++; if ({ack, err} !== 3'b100) begin errors++; $display("FAIL cont_ack1 got %b exp 100", {ack, err}); end
        @(negedge clk);
        checks++; if ({busy, ack} !== 3'b000) begin errors++; $display("FAIL cont_end got %b exp 000", {busy, ack}); end
    endtask

    task automatic test_read();
        req = 2'b01; op = 4'b0000; addr = 16'h0012; data_out = 8'hA5;
        @(negedge clk);
        checks++; if ({strobes, address, busy} !== {3'b100, 8'h12, 1'b1}) begin errors++; $display("FAIL rd_strobe got %h exp %h", {strobes, address, busy}, {3'b100, 8'h12, 1'b1}); end
        req = 2'b00;
        repeat (2) begin
            @(negedge clk);
            checks++; if ({ack, strobes} !== 5'd0) begin errors++; $display("FAIL rd_wait got %b exp 0", {ack, strobes}); end
        end
        @(negedge clk);
        checks++; if ({ack, err, rdata} !== {3'b010, 8'hA5}) begin errors++; $display("FAIL rd_ack got %h exp %h", {ack, err, rdata}, {3'b010, 8'hA5}); end
        @(negedge clk);
        checks++; if ({busy, ack} !== 3'b000) begin errors++; $display("FAIL rd_end got %b exp 000", {busy, ack}); end
    endtask

    task automatic test_illegal();
        req = 2'b10; op = 4'b1100; addr = 16'h9900;
        @(negedge clk);
        checks++; if ({ack, err, strobes} !== 6'b101000) begin errors++; $display("FAIL ill_ack got %b exp 101000", {ack, err, strobes}); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL ill_rdata got %h exp a5", rdata); end
        req = 2'b00;
        @(negedge clk);
        checks++; if ({ack, err, busy, strobes} !== 7'd0) begin errors++; $display("FAIL ill_end got %b exp 0", {ack, err, busy, strobes}); end
    endtask

    task automatic test_req_drop();
        req = 2'b01; op = 4'b0000; addr = 16'h0034; data_out = 8'h5A;
        @(negedge clk);
        req = 2'b00;
        checks++; if ({strobes, address} !== {3'b100, 8'h34}) begin errors++; $display("FAIL drop_strobe got %h exp 434", {strobes, address}); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (ack !== 2'b00) begin errors++; $display("FAIL drop_wait got %b exp 00", ack); end
        end
        @(negedge clk);
        checks++; if ({ack, rdata} !== {2'b01, 8'h5A}) begin errors++; $display("FAIL drop_ack got %h exp 15a", {ack, rdata}); end
        repeat (5) begin
            @(negedge clk);
            checks++; if ({busy, ack, strobes} !== 6'd0) begin errors++; $display("FAIL drop_quiet got %b exp 0", {busy, ack, strobes}); end
        end
    endtask

    task automatic test_reset_mid_erase();
        req = 2'b01; op = 4'b0010; addr = 16'h0040;
        @(negedge clk);
        req = 2'b00;
        checks++; if (strobes !== 3'b001) begin errors++; $display("FAIL rst_erase_strobe got %b exp 001", strobes); end
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (all_out !== 30'd0) begin errors++; $display("FAIL rst_mid_async got %h exp 0", all_out); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if ({ack, busy, strobes} !== 6'd0) begin errors++; $display("FAIL rst_quiet%0d got %b exp 0", i, {ack, busy, strobes}); end
        end
        req = 2'b01; op = 4'b0000; addr = 16'h0021; data_out = 8'hC3;
        @(negedge clk);
        req = 2'b00;
        checks++; if ({strobes, address} !== {3'b100, 8'h21}) begin errors++; $display("FAIL rst_rd_strobe got %h exp 421", {strobes, address}); end
        repeat (2) @(negedge clk);
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rst_rd_early got %b exp 00", ack); end
        @(negedge clk);
        checks++; if ({ack, rdata} !== {2'b01, 8'hC3}) begin errors++; $display("FAIL rst_rd_ack got %h exp 1c3", {ack, rdata}); end
    endtask

    task automatic test_back_to_back();
        logic got;
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        req = 2'b11; op = 4'b0101; addr = 16'h0000; wdata = 16'hB1A0;
        for (int k = 0; k < 6; k++) begin
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (ack !== 2'b00) begin got = 1'b1; break; end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy%0d got %b exp 1", k, busy); end
            end
            checks++; if (!got) begin errors++; $display("FAIL b2b_timeout%0d got no ack exp ack", k); end
            checks++; if ({ack, data_in} !== ((k % 2 == 1) ? {2'b10, 8'hB1} : {2'b01, 8'hA0})) begin
                errors++; $display("FAIL b2b_grant%0d got %h exp %h", k, {ack, data_in}, (k % 2 == 1) ? {2'b10, 8'hB1} : {2'b01, 8'hA0});
            end
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d got %b exp 0", k, busy); end
            if (k == 5) req = 2'b00;
        end
        repeat (3) begin
            @(negedge clk);
            checks++; if ({busy, ack} !== 3'b000) begin errors++; $display("FAIL b2b_end got %b exp 000", {busy, ack}); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention();
        test_read();
        test_illegal();
        test_req_drop();
        test_reset_mid_erase();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
